sclr_splitter: RTL



---
 rtl/sclr_splitter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sclr_splitter.sv
// Signed-digit scalar splitter: cuts each scalar into P_NUM_WIN windows and
// recodes them to {sign, magnitude} digits for the accumulator.
// Latency P_NUM_WIN cycles (one register stage per window, output register included).
// Backpressure: a single global enable freezes every stage while the output
// beat is held; input ready drops in the same cycle.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   axis_s_sclr_*               input scalar stream (data/valid/last/ready)
//   axis_m_red_scal_*           output digit stream; window k occupies
//                               data[k*P_RED_SCLR_W +: P_RED_SCLR_W], MSB = sign
//
// Build option: define SCLR_SPLIT_SIGNED_EN for signed-digit recoding; without
// it the windows are passed through unsigned with identical timing.
module sclr_splitter #(
  parameter int P_SCLR_W     = 253,
  parameter int P_NUM_WIN    = 7,
  parameter int P_RED_SCLR_W = 38
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [P_SCLR_W-1:0]               axis_s_sclr_data_i,
  input  logic                              axis_s_sclr_valid_i,
  input  logic                              axis_s_sclr_last_i,
  output logic                              axis_s_sclr_ready_o,
  output logic [P_NUM_WIN*P_RED_SCLR_W-1:0] axis_m_red_scal_data_o,
  output logic                              axis_m_red_scal_valid_o,
  output logic                              axis_m_red_scal_last_o,
  input  logic                              axis_m_red_scal_ready_i
);

  localparam int W  = P_RED_SCLR_W - 1;        // window / magnitude width
  localparam int PW = P_NUM_WIN * W;           // zero-padded scalar width
  localparam int DW = P_NUM_WIN * P_RED_SCLR_W;

`ifdef SCLR_SPLIT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  // Largest digit that stays positive: 2^(W-1).
  localparam logic [W:0] HALF = (W+1)'(1) << (W-1);

  // The top window must be strictly narrower than W bits so that
  // top window + carry never exceeds 2^(W-1).
  if (P_RED_SCLR_W < 2) begin : g_bad_red_w
    $error("sclr_splitter: P_RED_SCLR_W must be at least 2");
  end
  if (PW <= P_SCLR_W) begin : g_bad_win
    $error("sclr_splitter: P_NUM_WIN*(P_RED_SCLR_W-1) must exceed P_SCLR_W");
  end

  logic          en;
  logic [PW-1:0] sclr_pad;

  // One enable for the whole pipe: stalls freeze everything, bubbles included.
  assign en                  = !axis_m_red_scal_valid_o || axis_m_red_scal_ready_i;
  assign axis_s_sclr_ready_o = en && !rst;
  assign sclr_pad            = {{(PW-P_SCLR_W){1'b0}}, axis_s_sclr_data_i};

  for (genvar k = 0; k < P_NUM_WIN; k++) begin : g_stage
    // Stage k sees windows k..P_NUM_WIN-1; window k sits in the low W bits.
    localparam int RAW_W = (P_NUM_WIN - k) * W;

    logic             vld_in;
    logic             last_in;
    logic             c_in;
    logic [RAW_W-1:0] raw_in;
    logic [DW-1:0]    dig_in;

    logic [W-1:0]     win;
    logic [W:0]       d;
    logic [W-1:0]     neg;
    logic             rec;
    logic             sgn;
    logic [W-1:0]     mag;
    logic [DW-1:0]    dig_nxt;

    logic             vld_q;
    logic             last_q;
    logic [DW-1:0]    dig_q;

    if (k == 0) begin : g_head
      assign vld_in  = axis_s_sclr_valid_i;
      assign last_in = axis_s_sclr_last_i;
      assign c_in    = 1'b0;
      assign raw_in  = sclr_pad;
      assign dig_in  = '0;
    end else begin : g_body
      assign vld_in  = g_stage[k-1].vld_q;
      assign last_in = g_stage[k-1].last_q;
      assign c_in    = g_stage[k-1].g_fwd.c_q;
      assign raw_in  = g_stage[k-1].g_fwd.raw_q;
      assign dig_in  = g_stage[k-1].dig_q;
    end

    assign win = raw_in[W-1:0];
    assign d   = {1'b0, win} + {{W{1'b0}}, c_in};
    // 2^W - d modulo 2^W; d = 2^W yields 0, which is then emitted as +0.
    assign neg = '0 - d[W-1:0];

    // Recode to a negative digit only above 2^(W-1); the top window never recodes.
    assign rec = SIGNED_EN && (k < P_NUM_WIN - 1) && (d > HALF);
    assign mag = rec ? neg : (SIGNED_EN ? d[W-1:0] : win);
    assign sgn = rec && (neg != '0);

    always_comb begin
      dig_nxt = dig_in;
      dig_nxt[k*P_RED_SCLR_W +: P_RED_SCLR_W] = {sgn, mag};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q  <= 1'b0;
        last_q <= 1'b0;
        dig_q  <= '0;
      end else if (en) begin
        vld_q  <= vld_in;
        last_q <= last_in;
        dig_q  <= dig_nxt;
      end
    end

    // Carry and unresolved windows only exist between stages.
    if (k < P_NUM_WIN - 1) begin : g_fwd
      logic [RAW_W-W-1:0] raw_q;
      logic               c_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          raw_q <= '0;
          c_q   <= 1'b0;
        end else if (en) begin
          raw_q <= raw_in[RAW_W-1:W];
          c_q   <= rec;
        end
      end
    end
  end

  assign axis_m_red_scal_data_o  = g_stage[P_NUM_WIN-1].dig_q;
  assign axis_m_red_scal_valid_o = g_stage[P_NUM_WIN-1].vld_q;
  assign axis_m_red_scal_last_o  = g_stage[P_NUM_WIN-1].last_q;

endmodule
